// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the register-file writeback arbiter
package wb_pkg;

  localparam int REGIDX_W  = 5;
  localparam int WB_DATA_W = 32;

  typedef enum logic [0:0] {
    NORMAL     = 1'b0,
    FORCE_LOAD = 1'b1
  } wb_state_e;

  // One load-return queue entry at the default data width
  typedef struct packed {
    logic [REGIDX_W-1:0]  rd;
    logic [WB_DATA_W-1:0] data;
  } ldq_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// rtl/wb_load_queue.sv - circular FIFO buffering out-of-order load returns
module wb_load_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [REGIDX_W-1:0]      push_rd,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [REGIDX_W-1:0]      head_rd,
  output logic [WIDTH-1:0]         head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REGIDX_W-1:0] mem_rd   [DEPTH];
  logic [WIDTH-1:0]    mem_data [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_rd[wr_ptr]   <= push_rd;
      mem_data[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/load writeback arbiter with starvation guard
// Pending-load scoreboard and hazard_stall exist only when WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 32,
  parameter int LDQ_DEPTH    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [REGIDX_W-1:0]         alu_rd,
  input  logic [WIDTH-1:0]            alu_result,
  output logic                        alu_stall,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [REGIDX_W-1:0]         ld_rd,
  input  logic [WIDTH-1:0]            ld_data,
  input  logic                        ld_issue_valid,
  input  logic [REGIDX_W-1:0]         ld_issue_rd,
  input  logic                        rs1_valid,
  input  logic                        rs2_valid,
  input  logic [REGIDX_W-1:0]         rs1,
  input  logic [REGIDX_W-1:0]         rs2,
  output logic                        hazard_stall,
  output logic                        rf_wr_en,
  output logic [REGIDX_W-1:0]         rf_rd,
  output logic [WIDTH-1:0]            rf_result,
  output logic [WIDTH-1:0]            rf_ld_data,
  output logic                        rf_is_load,
  output logic [$clog2(LDQ_DEPTH):0]  ldq_count
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  wb_state_e                  state, state_next;
  logic [SC_W-1:0]            starve_cnt, starve_next;
  logic                       starve_inc;
  logic                       alu_grant, load_grant;
  logic                       q_push, q_full, q_empty;
  logic [$clog2(LDQ_DEPTH):0] q_count;
  logic [REGIDX_W-1:0]        q_head_rd;
  logic [WIDTH-1:0]           q_head_data;

  assign ld_ready = !reset && !q_full;
  // x0 returns are acknowledged but never written back
  assign q_push   = ld_valid && ld_ready && (ld_rd != '0);

  wb_load_queue #(
    .DEPTH (LDQ_DEPTH),
    .WIDTH (WIDTH)
  ) u_ldq (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_rd   (ld_rd),
    .push_data (ld_data),
    .pop       (load_grant),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head_rd   (q_head_rd),
    .head_data (q_head_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  always_comb begin
    alu_grant   = 1'b0;
    load_grant  = 1'b0;
    state_next  = state;
    starve_next = starve_cnt;
    if (!reset) begin
      if (state == FORCE_LOAD && !q_empty) load_grant = 1'b1;
      else if (alu_valid)                  alu_grant  = 1'b1;
      else if (!q_empty)                   load_grant = 1'b1;
    end
    starve_inc = !q_empty && !load_grant;
    if (load_grant)      starve_next = '0;
    else if (starve_inc) starve_next = starve_cnt + 1'b1;
    case (state)
      NORMAL:
        if (starve_inc && starve_cnt == SC_W'(STARVE_LIMIT - 1)) state_next = FORCE_LOAD;
      FORCE_LOAD:
        if (load_grant || q_empty) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  assign alu_stall  = alu_valid && load_grant;
  assign rf_wr_en   = alu_grant || load_grant;
  assign rf_rd      = load_grant ? q_head_rd : alu_rd;
  assign rf_is_load = load_grant;
  assign rf_result  = alu_result;
  assign rf_ld_data = q_head_data;
  assign ldq_count  = reset ? '0 : q_count;

`ifdef WB_SCOREBOARD_EN
  logic [NUMREGS-1:0] pending, set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (ld_issue_valid && ld_issue_rd != '0) set_mask[ld_issue_rd] = 1'b1;
    if (load_grant)                          clr_mask[q_head_rd]   = 1'b1;
  end

  // Re-issue to a register whose older load is retiring this cycle keeps it pending
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

  assign hazard_stall = !reset && ((rs1_valid && pending[rs1]) ||
                                   (rs2_valid && pending[rs2]) ||
                                   (alu_valid && pending[alu_rd]));
`else
  logic unused_sb;
  assign unused_sb    = ^{ld_issue_valid, ld_issue_rd, rs1_valid, rs1, rs2_valid, rs2};
  assign hazard_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        rs1_valid, rs2_valid;
  logic [4:0]  rs1, rs2;
  logic        hazard_stall;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_result;
  logic [31:0] rf_ld_data;
  logic        rf_is_load;
  logic [2:0]  ldq_count;

  int errors = 0;
  int checks = 0;
  ldq_entry_t exp_q [5];
  int idx;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_result     (alu_result),
    .alu_stall      (alu_stall),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_rd    (ld_issue_rd),
    .rs1_valid      (rs1_valid),
    .rs2_valid      (rs2_valid),
    .rs1            (rs1),
    .rs2            (rs2),
    .hazard_stall   (hazard_stall),
    .rf_wr_en       (rf_wr_en),
    .rf_rd          (rf_rd),
    .rf_result      (rf_result),
    .rf_ld_data     (rf_ld_data),
    .rf_is_load     (rf_is_load),
    .ldq_count      (ldq_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_issue_valid = 0; ld_issue_rd = 0;
    rs1_valid = 0; rs2_valid = 0; rs1 = 0; rs2 = 0;
    for (int k = 0; k < 5; k++) begin
      exp_q[k].rd   = 5'(11 + k);
      exp_q[k].data = 32'hA0 + 32'(k);
    end

    // Reset and idle
    settle;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_count", ldq_count, 0);
    tick; tick;
    reset = 1'b0;
    settle;
    chk("idle_ld_ready", ld_ready, 1);
    chk("idle_wr_en", rf_wr_en, 0);
    chk("idle_count", ldq_count, 0);
    chk("idle_hazard", hazard_stall, 0);

    // Load into an idle port
    ld_valid = 1; ld_rd = 5; ld_data = 32'hDEAD;
    settle;
    chk("ld0_no_write_yet", rf_wr_en, 0);
    tick;
    ld_valid = 0;
    settle;
    chk("ld0_wr_en", rf_wr_en, 1);
    chk("ld0_rd", rf_rd, 5);
    chk("ld0_is_load", rf_is_load, 1);
    chk("ld0_data", rf_ld_data, 32'hDEAD);
    chk("ld0_count1", ldq_count, 1);
    tick;
    chk("ld0_count0", ldq_count, 0);
    chk("ld0_idle", rf_wr_en, 0);

    // ALU priority with one starving load
    alu_valid = 1; alu_rd = 10; alu_result = 32'h1111;
    ld_valid = 1; ld_rd = 6; ld_data = 32'h66;
    settle;
    chk("pri_alu_wr", rf_wr_en, 1);
    chk("pri_alu_rd", rf_rd, 10);
    chk("pri_alu_res", rf_result, 32'h1111);
    tick;
    ld_valid = 0;
    for (int i = 0; i < 4; i++) begin
      settle;
      chk("starve_alu_grant", rf_is_load, 0);
      chk("starve_no_stall", alu_stall, 0);
      tick;
    end
    settle;
    chk("force_is_load", rf_is_load, 1);
    chk("force_stall", alu_stall, 1);
    chk("force_rd", rf_rd, 6);
    chk("force_data", rf_ld_data, 32'h66);
    tick;
    settle;
    chk("resume_alu", rf_is_load, 0);
    chk("resume_no_stall", alu_stall, 0);
    chk("resume_count", ldq_count, 0);

    // Queue full with ALU saturating, then ordered drain across pointer wrap
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1; ld_rd = exp_q[k].rd; ld_data = exp_q[k].data;
      settle;
      chk("fill_ready", ld_ready, 1);
      tick;
    end
    ld_rd = exp_q[4].rd; ld_data = exp_q[4].data;
    settle;
    chk("full_ready_low", ld_ready, 0);
    chk("full_alu_grant", rf_is_load, 0);
    tick;
    settle;
    chk("full_pop_no_pass", ld_ready, 0);
    chk("full_pop_is_load", rf_is_load, 1);
    chk("full_pop_rd", rf_rd, exp_q[0].rd);
    chk("full_pop_data", rf_ld_data, exp_q[0].data);
    chk("full_pop_stall", alu_stall, 1);
    chk("full_count", ldq_count, 4);
    tick;
    settle;
    chk("refill_ready", ld_ready, 1);
    chk("refill_count", ldq_count, 3);
    tick;
    ld_valid = 0;
    idx = 1;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      settle;
      if (rf_wr_en && rf_is_load) begin
        chk("drain_rd", rf_rd, exp_q[idx].rd);
        chk("drain_data", rf_ld_data, exp_q[idx].data);
        idx++;
      end
      tick;
    end
    chk("drain_all_written", idx, 5);
    alu_valid = 0;
    settle;
    chk("drain_count", ldq_count, 0);
    chk("drain_idle", rf_wr_en, 0);

    // Scoreboard: RAW on rs1, cleared by the load write
    ld_issue_valid = 1; ld_issue_rd = 7;
    tick;
    ld_issue_valid = 0;
    rs1_valid = 1; rs1 = 7;
    settle;
    chk("raw_stall", hazard_stall, SB);
    ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
    tick;
    ld_valid = 0;
    settle;
    chk("raw_wb_is_load", rf_is_load, 1);
    chk("raw_wb_rd", rf_rd, 7);
    chk("raw_stall_during_wb", hazard_stall, SB);
    tick;
    chk("raw_stall_cleared", hazard_stall, 0);
    rs1_valid = 0;

    // WAW via alu_rd, and x0 never pending
    ld_issue_valid = 1; ld_issue_rd = 7;
    tick;
    ld_issue_valid = 0;
    alu_valid = 1; alu_rd = 7;
    settle;
    chk("waw_stall", hazard_stall, SB);
    alu_rd = 8;
    settle;
    chk("waw_other_reg", hazard_stall, 0);
    alu_valid = 0;
    ld_issue_valid = 1; ld_issue_rd = 0;
    tick;
    ld_issue_valid = 0;
    rs2_valid = 1; rs2 = 0;
    settle;
    chk("x0_not_pending", hazard_stall, 0);
    rs2_valid = 0;

    // Re-issue to x7 in the cycle its old load writes back: stays pending
    ld_valid = 1; ld_rd = 7; ld_data = 32'h78;
    tick;
    ld_valid = 0;
    ld_issue_valid = 1; ld_issue_rd = 7;
    settle;
    chk("setwin_wb", rf_is_load, 1);
    tick;
    ld_issue_valid = 0;
    rs1_valid = 1; rs1 = 7;
    settle;
    chk("setwin_pending", hazard_stall, SB);
    rs1_valid = 0;

    // Reset mid-operation
    alu_valid = 1; alu_rd = 9;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1; ld_rd = 5'(20 + k); ld_data = 32'hC0 + 32'(k);
      ld_issue_valid = (k == 0); ld_issue_rd = 3;
      tick;
    end
    ld_valid = 0; ld_issue_valid = 0;
    rs1_valid = 1; rs1 = 3;
    settle;
    chk("mid_count", ldq_count, 3);
    chk("mid_stall", hazard_stall, SB);
    chk("mid_alu_grant", rf_is_load, 0);
    reset = 1;
    settle;
    chk("mid_rst_count", ldq_count, 0);
    chk("mid_rst_wr_en", rf_wr_en, 0);
    chk("mid_rst_ready", ld_ready, 0);
    chk("mid_rst_hazard", hazard_stall, 0);
    chk("mid_rst_alu_stall", alu_stall, 0);
    tick;
    reset = 0; alu_valid = 0;
    settle;
    chk("post_rst_count", ldq_count, 0);
    chk("post_rst_wr_en", rf_wr_en, 0);
    chk("post_rst_x3", hazard_stall, 0);
    rs1 = 7;
    settle;
    chk("post_rst_x7", hazard_stall, 0);
    tick;
    chk("post_rst_no_stale", rf_wr_en, 0);
    rs1_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
